// File: rtl/mem_resp_queue.sv
// In-order response tracker for MEM-stage data-SRAM transactions: records per-request
// metadata, matches data_ok beats oldest-first, extends load data and hands results to WB.
module mem_resp_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             acc_ready,
  input  logic             acc_fire,
  input  logic             acc_is_store,
  input  logic [2:0]       acc_ld_op,
  input  logic [1:0]       acc_offset,
  input  logic [TAG_W-1:0] acc_tag,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_is_store,
  output logic             busy,
  output logic             err_spurious
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d, pend_q, pend_d;
  logic             err_q;

  logic             is_store_q [DEPTH];
  logic [2:0]       ld_op_q    [DEPTH];
  logic [1:0]       offset_q   [DEPTH];
  logic [TAG_W-1:0] tag_q      [DEPTH];
  logic [31:0]      data_q     [DEPTH];
  logic             filled_q   [DEPTH];
  logic             cancel_q   [DEPTH];

  logic alloc, fill, spurious, head_live, discard, retire;

  function automatic logic [31:0] extract(input logic st, input logic [2:0] op,
                                          input logic [1:0] off, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (op)
      3'b001:  r = {{24{b[7]}}, b};
      3'b010:  r = {24'd0, b};
      3'b011:  r = {{16{h[15]}}, h};
      3'b100:  r = {16'd0, h};
      default: r = d;
    endcase
    return st ? 32'd0 : r;
  endfunction

  assign acc_ready = (count_q < FULL);
  assign alloc     = acc_fire & acc_ready;
  // A same-cycle alloc cannot absorb a beat: only registered pend decides.
  assign fill      = data_ok & (pend_q != '0);
  assign spurious  = data_ok & (pend_q == '0);

  assign head_live = (count_q != '0) & filled_q[rd_ptr_q];
  assign out_valid = head_live & ~cancel_q[rd_ptr_q] & ~flush;
  assign discard   = head_live & cancel_q[rd_ptr_q];
  assign retire    = (out_valid & out_ready) | discard;

  assign out_data     = data_q[rd_ptr_q];
  assign out_tag      = tag_q[rd_ptr_q];
  assign out_is_store = is_store_q[rd_ptr_q];
  assign busy         = (count_q != '0);
  assign err_spurious = err_q;

  always_comb begin
    count_d = count_q;
    pend_d  = pend_q;
    case ({alloc, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({alloc, fill})
      2'b10:   pend_d = pend_q + CNT_W'(1);
      2'b01:   pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  // Control state: pointers, occupancy, per-entry status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        filled_q[i] <= 1'b0;
        cancel_q[i] <= 1'b0;
      end
    end else begin
      if (alloc)    wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      if (fill)     fill_ptr_q <= fill_ptr_q + PTR_W'(1);
      if (retire)   rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
      if (spurious) err_q      <= 1'b1;
      count_q <= count_d;
      pend_q  <= pend_d;
      // Free slots may be marked too; alloc rewrites cancel before they matter.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush)
          cancel_q[i] <= 1'b1;
        if (fill && fill_ptr_q == PTR_W'(i))
          filled_q[i] <= 1'b1;
        if (alloc && wr_ptr_q == PTR_W'(i)) begin
          filled_q[i] <= 1'b0;
          cancel_q[i] <= flush;
        end
      end
    end
  end

  // Payload storage, not reset
  always_ff @(posedge clk) begin
    if (alloc) begin
      is_store_q[wr_ptr_q] <= acc_is_store;
      ld_op_q[wr_ptr_q]    <= acc_ld_op;
      offset_q[wr_ptr_q]   <= acc_offset;
      tag_q[wr_ptr_q]      <= acc_tag;
    end
    if (fill)
      data_q[fill_ptr_q] <= extract(is_store_q[fill_ptr_q], ld_op_q[fill_ptr_q],
                                    offset_q[fill_ptr_q], rdata);
  end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue: extension, ordering, backpressure, flush,
// spurious responses, wrap-around and mid-run reset against hand-computed values.
module tb_mem_resp_queue;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             acc_ready;
  logic             acc_fire;
  logic             acc_is_store;
  logic [2:0]       acc_ld_op;
  logic [1:0]       acc_offset;
  logic [TAG_W-1:0] acc_tag;
  logic             data_ok;
  logic [31:0]      rdata;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_is_store;
  logic             busy;
  logic             err_spurious;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_resp_queue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .acc_ready(acc_ready), .acc_fire(acc_fire),
    .acc_is_store(acc_is_store), .acc_ld_op(acc_ld_op), .acc_offset(acc_offset),
    .acc_tag(acc_tag), .data_ok(data_ok), .rdata(rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_is_store(out_is_store), .busy(busy),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction end to end: alloc, beat next cycle, result the cycle after,
  // optional WB stall, then retire.
  task automatic ld_one(input string nm, input logic st, input logic [2:0] op,
                        input logic [1:0] off, input logic [TAG_W-1:0] tag,
                        input logic [31:0] rd, input logic [31:0] exp, input int stall);
    acc_fire = 1'b1; acc_is_store = st; acc_ld_op = op; acc_offset = off; acc_tag = tag;
    tick;
    acc_fire = 1'b0; data_ok = 1'b1; rdata = rd;
    #1;
    chk({nm, "_lat0"}, 32'(out_valid), 32'd0);
    tick;
    data_ok = 1'b0; rdata = 32'hDEADBEEF;
    #1;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
    chk({nm, "_store"}, 32'(out_is_store), 32'(st));
    for (int s = 0; s < stall; s++) begin
      tick;
      #1;
      chk({nm, "_hold"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    #1;
    chk({nm, "_drained"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; acc_fire = 1'b0; acc_is_store = 1'b0; acc_ld_op = 3'd0;
    acc_offset = 2'd0; acc_tag = '0; data_ok = 1'b0; rdata = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    #1;
    chk("rst_acc_ready", 32'(acc_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_spurious), 32'd0);

    // Byte extraction
    ld_one("ldb", 1'b0, 3'b001, 2'd2, 5'd3, 32'h12803456, 32'hFFFFFF80, 0);
    ld_one("ldbu", 1'b0, 3'b010, 2'd2, 5'd3, 32'h12803456, 32'h00000080, 0);

    // Fill to capacity; a fifth request while full must be ignored
    for (int i = 0; i < 4; i++) begin
      acc_fire = 1'b1; acc_is_store = 1'b0; acc_ld_op = 3'b000; acc_offset = 2'd0;
      acc_tag = 5'(10 + i);
      tick;
    end
    acc_tag = 5'd31;
    #1;
    chk("full_acc_ready", 32'(acc_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    tick;
    acc_fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_ok = 1'b1; rdata = 32'hA0000000 + 32'(i);
      tick;
    end
    data_ok = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("full_no_bypass", 32'(acc_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("order_valid", 32'(out_valid), 32'd1);
      chk("order_tag", 32'(out_tag), 32'(10 + i));
      chk("order_data", out_data, 32'hA0000000 + 32'(i));
      tick;
      #1;
      if (i == 0) chk("ready_after_retire", 32'(acc_ready), 32'd1);
    end
    out_ready = 1'b0;
    chk("full_drained", 32'(busy), 32'd0);
    chk("full_drained_valid", 32'(out_valid), 32'd0);

    // Flush with two loads outstanding
    acc_fire = 1'b1; acc_ld_op = 3'b000; acc_tag = 5'd1;
    tick;
    acc_tag = 5'd2;
    tick;
    acc_fire = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_cycle_valid", 32'(out_valid), 32'd0);
    tick;
    flush = 1'b0; data_ok = 1'b1; rdata = 32'h1;
    #1;
    chk("fl_beat1_valid", 32'(out_valid), 32'd0);
    tick;
    rdata = 32'h2;
    #1;
    chk("fl_beat2_valid", 32'(out_valid), 32'd0);
    tick;
    data_ok = 1'b0;
    #1;
    chk("fl_disc_valid", 32'(out_valid), 32'd0);
    chk("fl_busy_t1", 32'(busy), 32'd1);
    tick;
    #1;
    chk("fl_busy_t2", 32'(busy), 32'd0);
    chk("fl_err", 32'(err_spurious), 32'd0);
    out_ready = 1'b0;

    // Alloc in the flush cycle is cancelled too; the next load comes out first
    acc_fire = 1'b1; acc_tag = 5'd1;
    tick;
    acc_tag = 5'd2; flush = 1'b1;
    tick;
    flush = 1'b0; acc_tag = 5'd7;
    tick;
    acc_fire = 1'b0; out_ready = 1'b1; data_ok = 1'b1; rdata = 32'h11;
    #1;
    chk("fa_b1_valid", 32'(out_valid), 32'd0);
    tick;
    rdata = 32'h22;
    #1;
    chk("fa_b2_valid", 32'(out_valid), 32'd0);
    tick;
    rdata = 32'hCAFEF00D;
    #1;
    chk("fa_b3_valid", 32'(out_valid), 32'd0);
    tick;
    data_ok = 1'b0;
    #1;
    chk("fa_valid", 32'(out_valid), 32'd1);
    chk("fa_tag", 32'(out_tag), 32'd7);
    chk("fa_data", out_data, 32'hCAFEF00D);
    tick;
    out_ready = 1'b0;
    #1;
    chk("fa_drained", 32'(busy), 32'd0);

    // Spurious beat on an empty queue, then one alongside an alloc
    data_ok = 1'b1; rdata = 32'h99;
    tick;
    data_ok = 1'b0;
    #1;
    chk("sp_err", 32'(err_spurious), 32'd1);
    chk("sp_busy", 32'(busy), 32'd0);
    chk("sp_acc_ready", 32'(acc_ready), 32'd1);
    acc_fire = 1'b1; acc_ld_op = 3'b000; acc_tag = 5'd4; data_ok = 1'b1; rdata = 32'h55;
    tick;
    acc_fire = 1'b0; data_ok = 1'b0;
    #1;
    chk("sp_same_cycle_valid", 32'(out_valid), 32'd0);
    chk("sp_same_cycle_busy", 32'(busy), 32'd1);
    data_ok = 1'b1; rdata = 32'h66;
    tick;
    data_ok = 1'b0;
    #1;
    chk("sp_real_valid", 32'(out_valid), 32'd1);
    chk("sp_real_data", out_data, 32'h66);
    chk("sp_real_tag", 32'(out_tag), 32'd4);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    #1;
    chk("sp_drained", 32'(busy), 32'd0);
    chk("sp_sticky", 32'(err_spurious), 32'd1);

    // Halfword stream across pointer wrap, with a store in the middle
    ld_one("h0", 1'b0, 3'b011, 2'd0, 5'd20, 32'h12348765, 32'hFFFF8765, 0);
    ld_one("h1", 1'b0, 3'b100, 2'd0, 5'd21, 32'h12348765, 32'h00008765, 1);
    ld_one("h2", 1'b0, 3'b011, 2'd2, 5'd22, 32'h9ABC0001, 32'hFFFF9ABC, 2);
    ld_one("h3", 1'b0, 3'b100, 2'd2, 5'd23, 32'h9ABC0001, 32'h00009ABC, 0);
    ld_one("h4", 1'b0, 3'b011, 2'd3, 5'd24, 32'h7FFF8000, 32'h00007FFF, 1);
    ld_one("h5", 1'b0, 3'b100, 2'd1, 5'd25, 32'h7FFF8000, 32'h00008000, 2);
    ld_one("st", 1'b1, 3'b000, 2'd0, 5'd26, 32'h13572468, 32'h00000000, 1);
    ld_one("h7", 1'b0, 3'b011, 2'd1, 5'd27, 32'h00008000, 32'hFFFF8000, 0);
    ld_one("h8", 1'b0, 3'b100, 2'd3, 5'd28, 32'hFFFF0000, 32'h0000FFFF, 1);
    ld_one("h9", 1'b0, 3'b011, 2'd2, 5'd29, 32'hFFFF0000, 32'hFFFFFFFF, 2);
    ld_one("h10", 1'b0, 3'b011, 2'd0, 5'd30, 32'h55557ABC, 32'h00007ABC, 0);

    // Reset mid-operation empties the queue
    acc_fire = 1'b1; acc_is_store = 1'b0; acc_tag = 5'd5;
    tick;
    tick;
    acc_fire = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_acc_ready", 32'(acc_ready), 32'd1);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_err", 32'(err_spurious), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
